gemm_uop_decode: RTL and testbench

- Consumer side of the micro-op fetch interface.
- Accepts a micro-op address (upc) plus six loop offsets per beat and reads the 32-bit micro-op from the synchronous uop SRAM.
- Adds the offsets to the micro-op's acc/inp/wgt index fields and presents final buffer indices to the GEMM datapath.
- Two-stage pipeline, valid/ready on both sides, full throughput, no beat loss under backpressure.

---
 rtl/gemm_uop_decode.sv | 107 ++++++++++
 tb/tb_gemm_uop_decode.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_uop_decode.sv
// rtl/gemm_uop_decode.sv - micro-op fetch consumer: SRAM read, offset add, indexed output
module gemm_uop_decode #(
    parameter int UPC_WIDTH     = 13,
    parameter int UOP_WIDTH     = 32,
    parameter int ACC_IDX_WIDTH = 11,
    parameter int INP_IDX_WIDTH = 11,
    parameter int WGT_IDX_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [UPC_WIDTH-1:0]     upc,
    input  logic [ACC_IDX_WIDTH-1:0] dst_offset_out,
    input  logic [ACC_IDX_WIDTH-1:0] dst_offset_in,
    input  logic [INP_IDX_WIDTH-1:0] src_offset_out,
    input  logic [INP_IDX_WIDTH-1:0] src_offset_in,
    input  logic [WGT_IDX_WIDTH-1:0] wgt_offset_out,
    input  logic [WGT_IDX_WIDTH-1:0] wgt_offset_in,
    output logic                     uop_rd_en,
    output logic [UPC_WIDTH-1:0]     uop_rd_addr,
    input  logic [UOP_WIDTH-1:0]     uop_rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_IDX_WIDTH-1:0] acc_idx,
    output logic [INP_IDX_WIDTH-1:0] inp_idx,
    output logic [WGT_IDX_WIDTH-1:0] wgt_idx
);

    localparam int INP_LSB = ACC_IDX_WIDTH;
    localparam int WGT_LSB = ACC_IDX_WIDTH + INP_IDX_WIDTH;

    logic                     s1_valid;
    logic                     s1_hold_valid;
    logic                     rd_pending;
    logic [UOP_WIDTH-1:0]     s1_uop_hold;
    logic [ACC_IDX_WIDTH-1:0] dst_sum;
    logic [INP_IDX_WIDTH-1:0] src_sum;
    logic [WGT_IDX_WIDTH-1:0] wgt_sum;

    logic                     in_fire;
    logic                     advance;
    logic [UOP_WIDTH-1:0]     uop_word;
    logic [ACC_IDX_WIDTH-1:0] uop_acc;
    logic [INP_IDX_WIDTH-1:0] uop_inp;
    logic [WGT_IDX_WIDTH-1:0] uop_wgt;

    assign advance     = s1_valid & (~out_valid | out_ready);
    assign in_ready    = ~s1_valid | advance;
    assign in_fire     = in_valid & in_ready;
    assign uop_rd_en   = in_fire & ~rst;
    assign uop_rd_addr = upc;

    // SRAM data lives on the bus for one cycle only; afterwards the captured copy wins
    assign uop_word = s1_hold_valid ? s1_uop_hold : uop_rd_data;
    assign uop_acc  = uop_word[ACC_IDX_WIDTH-1:0];
    assign uop_inp  = uop_word[INP_LSB +: INP_IDX_WIDTH];
    assign uop_wgt  = uop_word[WGT_LSB +: WGT_IDX_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_hold_valid <= 1'b0;
            rd_pending    <= 1'b0;
            out_valid     <= 1'b0;
            acc_idx       <= '0;
            inp_idx       <= '0;
            wgt_idx       <= '0;
        end else begin
            rd_pending <= in_fire;

            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            if (advance) begin
                s1_hold_valid <= 1'b0;
            end else if (rd_pending) begin
                s1_hold_valid <= 1'b1;
            end

            if (advance) begin
                out_valid <= 1'b1;
                acc_idx   <= uop_acc + dst_sum;
                inp_idx   <= uop_inp + src_sum;
                wgt_idx   <= uop_wgt + wgt_sum;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Datapath registers are qualified by the valid flags above and need no reset
    always_ff @(posedge clk) begin
        if (in_fire) begin
            dst_sum <= dst_offset_out + dst_offset_in;
            src_sum <= src_offset_out + src_offset_in;
            wgt_sum <= wgt_offset_out + wgt_offset_in;
        end
        if (rd_pending && !advance) begin
            s1_uop_hold <= uop_rd_data;
        end
    end

endmodule

// File: tb/tb_gemm_uop_decode.sv
// tb/tb_gemm_uop_decode.sv - self-checking bench for gemm_uop_decode
module tb_gemm_uop_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] upc;
    logic [10:0] dst_offset_out, dst_offset_in;
    logic [10:0] src_offset_out, src_offset_in;
    logic [9:0]  wgt_offset_out, wgt_offset_in;
    logic        uop_rd_en;
    logic [12:0] uop_rd_addr;
    logic [31:0] uop_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] acc_idx;
    logic [10:0] inp_idx;
    logic [9:0]  wgt_idx;

    gemm_uop_decode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .upc(upc),
        .dst_offset_out(dst_offset_out), .dst_offset_in(dst_offset_in),
        .src_offset_out(src_offset_out), .src_offset_in(src_offset_in),
        .wgt_offset_out(wgt_offset_out), .wgt_offset_in(wgt_offset_in),
        .uop_rd_en(uop_rd_en), .uop_rd_addr(uop_rd_addr), .uop_rd_data(uop_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_idx(acc_idx), .inp_idx(inp_idx), .wgt_idx(wgt_idx)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM; the bus carries junk whenever no read was issued
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        uop_rd_data <= uop_rd_en ? mem[uop_rd_addr[7:0]] : $urandom;
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // out_ready pattern: 0 = always 1, 1 = low for rel cycles 2..6, 2 = alternating
    int mode = 0;
    int ordy_ctr = 0;
    always @(posedge clk) begin
        #2;
        ordy_ctr++;
        case (mode)
            1:       out_ready = !(ordy_ctr >= 2 && ordy_ctr <= 6);
            2:       out_ready = ordy_ctr[0];
            default: out_ready = 1'b1;
        endcase
    end

    typedef struct {
        logic [10:0] a;
        logic [10:0] i;
        logic [9:0]  w;
        int          t;
    } beat_t;

    beat_t       q[$];
    logic [10:0] log_a[$];
    logic [10:0] log_i[$];
    logic [9:0]  log_w[$];
    int          cyc = 0;
    logic        hold_chk = 1'b0;
    logic [10:0] held_a, held_i;
    logic [9:0]  held_w;

    // Model: beats leave in order, two cycles after acceptance at the earliest,
    // and the pipe holds at most two beats
    always @(negedge clk) begin
        logic  fire;
        beat_t b;
        logic [31:0] word;
        cyc++;
        if (rst) begin
            check("rd_en_in_reset", uop_rd_en, 0);
            q.delete();
            hold_chk = 1'b0;
        end else begin
            fire = in_valid && in_ready;
            check("in_ready", in_ready, (q.size() < 2) || out_ready);
            if (q.size() > 0) check("out_valid", out_valid, (cyc - q[0].t) >= 2);
            else              check("out_valid", out_valid, 0);
            check("rd_en", uop_rd_en, fire);
            if (fire) check("rd_addr", uop_rd_addr, upc);
            if (hold_chk) begin
                check("stall_acc", acc_idx, held_a);
                check("stall_inp", inp_idx, held_i);
                check("stall_wgt", wgt_idx, held_w);
            end
            hold_chk = 1'b0;
            if (out_valid && q.size() > 0) begin
                check("acc_idx", acc_idx, q[0].a);
                check("inp_idx", inp_idx, q[0].i);
                check("wgt_idx", wgt_idx, q[0].w);
                if (out_ready) begin
                    log_a.push_back(acc_idx);
                    log_i.push_back(inp_idx);
                    log_w.push_back(wgt_idx);
                    void'(q.pop_front());
                end else begin
                    hold_chk = 1'b1;
                    held_a = acc_idx;
                    held_i = inp_idx;
                    held_w = wgt_idx;
                end
            end
            if (fire) begin
                word = mem[upc[7:0]];
                b.a = word[10:0] + dst_offset_out + dst_offset_in;
                b.i = word[21:11] + src_offset_out + src_offset_in;
                b.w = word[31:22] + wgt_offset_out + wgt_offset_in;
                b.t = cyc;
                q.push_back(b);
            end
        end
    end

    task automatic send(input logic [12:0] a, input logic [10:0] d_o, input logic [10:0] d_i,
                        input logic [10:0] s_o, input logic [10:0] s_i,
                        input logic [9:0] w_o, input logic [9:0] w_i);
        int   n = 0;
        logic ok;
        in_valid = 1'b1; upc = a;
        dst_offset_out = d_o; dst_offset_in = d_i;
        src_offset_out = s_o; src_offset_in = s_i;
        wgt_offset_out = w_o; wgt_offset_in = w_i;
        do begin
            @(negedge clk);
            ok = in_ready;
            n++;
        end while (!ok && n < 64);
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input int idx,
                             input logic [10:0] a, input logic [10:0] i, input logic [9:0] w);
        if (idx < log_a.size()) begin
            check({name, "_acc"}, log_a[idx], a);
            check({name, "_inp"}, log_i[idx], i);
            check({name, "_wgt"}, log_w[idx], w);
        end else begin
            check({name, "_missing"}, idx, log_a.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int base;
        for (int i = 0; i < 256; i++) mem[i] = {i[9:0], i[10:0], i[10:0]};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; upc = '0;
        dst_offset_out = '0; dst_offset_in = '0; src_offset_out = '0; src_offset_in = '0;
        wgt_offset_out = '0; wgt_offset_in = '0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_acc", acc_idx, 0);
        check("reset_inp", inp_idx, 0);
        check("reset_wgt", wgt_idx, 0);
        idle(1);

        // 1: single beat
        mem[5] = (32'd3 << 22) | (32'd7 << 11) | 32'd9;
        base = log_a.size();
        send(5, 16, 1, 32, 2, 4, 1);
        idle(4);
        check("t1_count", log_a.size() - base, 1);
        check_log("t1", base, 26, 41, 8);
        mem[5] = {10'd5, 11'd5, 11'd5};

        // 2: streaming
        base = log_a.size();
        for (int i = 0; i < 8; i++) send(i[12:0], 0, 0, 0, 0, 0, 0);
        idle(4);
        check("t2_count", log_a.size() - base, 8);
        for (int i = 0; i < 8; i++) check_log("t2", base + i, i[10:0], i[10:0], i[9:0]);

        // 3: backpressure window
        base = log_a.size();
        mode = 1; ordy_ctr = -1;
        for (int i = 0; i < 4; i++) send(i[12:0], 0, 0, 0, 0, 0, 0);
        idle(10);
        mode = 0;
        check("t3_count", log_a.size() - base, 4);
        for (int i = 0; i < 4; i++) check_log("t3", base + i, i[10:0], i[10:0], i[9:0]);

        // 4: index wrap
        mem[8] = {10'h3FF, 11'h000, 11'h7FF};
        base = log_a.size();
        send(8, 11'h001, 11'h000, 0, 0, 10'h3FF, 10'h002);
        idle(4);
        check_log("t4", base, 11'h000, 11'h000, 10'h000);

        // 5: reset with two beats in flight
        send(0, 0, 0, 0, 0, 0, 0);
        send(1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_out_valid", out_valid, 0);
        check("t5_in_ready", in_ready, 1);
        check("t5_rd_en", uop_rd_en, 0);
        idle(1);
        base = log_a.size();
        send(2, 0, 0, 0, 0, 0, 0);
        idle(5);
        check("t5_count", log_a.size() - base, 1);
        check_log("t5", base, 2, 2, 2);

        // 6: alternating out_ready, continuous input
        base = log_a.size();
        mode = 2;
        for (int i = 0; i < 8; i++) send(i[12:0], i[10:0], 1, 0, 0, 0, 0);
        idle(12);
        mode = 0;
        idle(2);
        check("t6_count", log_a.size() - base, 8);
        for (int i = 0; i < 8; i++) check_log("t6", base + i, 11'(2 * i + 1), i[10:0], i[9:0]);

        check("drained", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
